// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Package : muldiv_pkg
// Shared operation/state encodings and constants for the RV32M muldiv unit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic op_signed_a(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_signed_b(op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Interface : muldiv_unit_if
// Start/operand request and result/writeback response of the muldiv unit.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dataA;
  logic [XLEN-1:0] dataB;
  logic [4:0]      addD;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, dataA, dataB, addD,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, dataA, dataB, addD,
    output busy, done, result, rd_out
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Iterative RV32M multiply/divide (shift-add / restoring) on one 64-bit shifter.
// Option : MULDIV_EARLY_OUT_EN (trivial/special ops complete straight from IDLE)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  import muldiv_pkg::*;

  localparam logic [4:0] LAST_CALC = 5'd30;

  state_e            state, state_nxt;
  logic [4:0]        cnt;
  op_e               op;
  logic [4:0]        rd_cap;
  logic              neg_res;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic              done_reg;
  logic [XLEN-1:0]   result_reg;
  logic [4:0]        rd_out_reg;

  // Start-cycle decode of the incoming request
  op_e             in_op;
  logic            in_sa, in_sb, in_div, in_div0, in_ovf;
  logic [XLEN-1:0] in_mag_a, in_mag_b;

  assign in_op    = op_e'(bus.funct3);
  assign in_sa    = op_signed_a(in_op) & bus.dataA[XLEN-1];
  assign in_sb    = op_signed_b(in_op) & bus.dataB[XLEN-1];
  assign in_mag_a = in_sa ? -bus.dataA : bus.dataA;
  assign in_mag_b = in_sb ? -bus.dataB : bus.dataB;
  assign in_div   = bus.funct3[2];
  assign in_div0  = in_div && (bus.dataB == '0);
  assign in_ovf   = (in_op == OP_DIV || in_op == OP_REM) &&
                    (bus.dataA == INT_MIN) && (bus.dataB == '1);

`ifdef MULDIV_EARLY_OUT_EN
  logic            in_early;
  logic [XLEN-1:0] in_early_val;

  assign in_early = in_div0 || in_ovf ||
                    (!in_div && (bus.dataA == '0 || bus.dataB == '0));

  always_comb begin
    in_early_val = '0;
    if (in_div0)
      in_early_val = (in_op == OP_DIV || in_op == OP_DIVU) ? DIV0_QUOT : bus.dataA;
    else if (in_ovf)
      in_early_val = (in_op == OP_DIV) ? INT_MIN : '0;
  end
`endif

  // One iteration of the shared shifter: multiply adds opnd into the high
  // half, divide trial-subtracts opnd from the 33-bit partial remainder.
  logic [XLEN:0]     mul_sum, div_pr, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_pr   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_pr - {1'b0, opnd};
  assign div_ge   = div_pr >= {1'b0, opnd};

  always_comb begin
    step = {mul_sum, acc[XLEN-1:1]};
    if (op[2])
      step = div_ge ? {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1}
                    : {div_pr[XLEN-1:0],   acc[XLEN-2:0], 1'b0};
  end

  // FIN runs the last iteration and the sign fixup in the same cycle.
  // REM/REMU by zero needs no forcing: the remainder path yields the dividend.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_val;

  assign prod_fix = neg_res ? -step : step;
  assign quot_fix = neg_res ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem_fix  = neg_res ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

  always_comb begin
    final_val = '0;
    unique case (op)
      OP_MUL:                        final_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_val = div0 ? DIV0_QUOT :
                                                 ovf  ? INT_MIN   : quot_fix;
      OP_REM, OP_REMU:               final_val = ovf ? '0 : rem_fix;
      default:                       final_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
`ifdef MULDIV_EARLY_OUT_EN
        if (bus.start && !in_early) state_nxt = CALC;
`else
        if (bus.start) state_nxt = CALC;
`endif
      end
      CALC:    if (cnt == LAST_CALC) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op         <= OP_MUL;
      rd_cap     <= '0;
      neg_res    <= 1'b0;
      div0       <= 1'b0;
      ovf        <= 1'b0;
      opnd       <= '0;
      acc        <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef MULDIV_EARLY_OUT_EN
            if (in_early) begin
              result_reg <= in_early_val;
              rd_out_reg <= bus.addD;
              done_reg   <= 1'b1;
            end else
`endif
            begin
              cnt     <= '0;
              op      <= in_op;
              rd_cap  <= bus.addD;
              neg_res <= (in_op == OP_REM || in_op == OP_REMU) ? in_sa : (in_sa ^ in_sb);
              div0    <= in_div0;
              ovf     <= in_ovf;
              opnd    <= in_div ? in_mag_b : in_mag_a;
              acc     <= {{XLEN{1'b0}}, (in_div ? in_mag_a : in_mag_b)};
            end
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + 5'd1;
        end
        FIN: begin
          result_reg <= final_val;
          rd_out_reg <= rd_cap;
          done_reg   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.rd_out = rd_out_reg;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Self-checking bench for muldiv_unit against an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit and signed 32-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (f == 3'b000 || f == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    case (f)
      3'b000:                 return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && b == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is just after a rising edge; start is sampled on the next edge.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int poke_k,
                        input string tag);
    int   lat, seen;
    logic busy_ok, busy_at_done;
    lat = exp_lat(f, a, b);
    seen = 0; busy_ok = 1'b1; busy_at_done = 1'b0;
    bus.start = 1'b1; bus.funct3 = f; bus.dataA = a; bus.dataB = b; bus.addD = rd;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        seen = k;
        busy_at_done = bus.busy;
      end else if (k <= 32 && bus.busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (k == 1) begin
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        bus.addD   = 5'($urandom);
      end
      if (seen == 0 && poke_k > 0 && k == poke_k)   bus.start = 1'b1;
      if (seen == 0 && poke_k > 0 && k == poke_k+1) bus.start = 1'b0;
    end
    chk({tag, " latency"}, 32'(seen), 32'(lat));
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " rd_out"}, {27'b0, bus.rd_out}, {27'b0, rd});
    chk({tag, " busy during op"}, {31'b0, busy_ok}, 32'(lat == 33 ? 1 : 1));
    chk({tag, " busy at done"}, {31'b0, busy_at_done}, 32'h0);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    int pulses;
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk({tag, " no extra done"}, 32'(pulses), 32'h0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          aborted_dones;

    bus.start = 1'b0; bus.funct3 = 3'b0; bus.dataA = '0; bus.dataB = '0; bus.addD = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",   {31'b0, bus.busy}, 32'h0);
    chk("reset done",   {31'b0, bus.done}, 32'h0);
    chk("reset result", bus.result, 32'h0);
    chk("reset rd_out", {27'b0, bus.rd_out}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0, "MUL 7*-3");
    idle_cycles(2, "MUL 7*-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0, "MULH min*min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0, "MULHU");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0, "MULHSU");
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2,   5'd4,  32'hFFFF_FFFD, 0, "DIV -7/2");
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2,   5'd6,  32'hFFFF_FFFF, 0, "REM -7/2");
    run_op(3'b101, 32'd100,       32'd7,   5'd7,  32'd14,        0, "DIVU 100/7");
    run_op(3'b111, 32'd100,       32'd7,   5'd0,  32'd2,         0, "REMU 100/7");
    run_op(3'b100, 32'd5,         32'd0,   5'd8,  32'hFFFF_FFFF, 0, "DIV 5/0");
    run_op(3'b110, 32'd5,         32'd0,   5'd9,  32'd5,         0, "REM 5/0");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 0, "DIV ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0,    0, "REM ovf");
    run_op(3'b000, 32'd0,         32'd1234, 5'd12, 32'h0,        0, "MUL zero");
    idle_cycles(3, "specials");

    // start in the done cycle of the previous op, then a stray start mid-CALC
    run_op(3'b101, 32'd1000, 32'd3, 5'd13, 32'd333, 0,  "b2b first");
    run_op(3'b111, 32'd1000, 32'd3, 5'd14, 32'd1,   0,  "b2b second");
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFF2, 10, "DIV with mid start");
    idle_cycles(3, "mid start");

    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      rd = 5'($urandom);
      run_op(f, a, b, rd, ref_op(f, a, b), (i % 5 == 4) ? 20 : 0, $sformatf("rand%0d f%0d", i, f));
      if (i % 3 == 0) idle_cycles(1, "rand gap");
    end

    // Abort: reset at C+10 of a long op
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.dataA = 32'h1234_5678; bus.dataB = 32'h0BAD_F00D; bus.addD = 5'd21;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort busy",   {31'b0, bus.busy}, 32'h0);
    chk("abort done",   {31'b0, bus.done}, 32'h0);
    chk("abort result", bus.result, 32'h0);
    chk("abort rd_out", {27'b0, bus.rd_out}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    aborted_dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) aborted_dones++;
    end
    chk("abort no done", 32'(aborted_dones), 32'h0);

    run_op(3'b000, 32'd6, 32'd7, 5'd31, 32'd42, 0, "after abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
